// File: rtl/mu0_mem_ctrl.sv
// MU0 memory controller: registers one core request per transfer, holds it on the memory bus
// until mem_ack arrives or the wait budget runs out, and stalls the core through ready.
module mu0_mem_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memrq,
  input  logic        rnw,
  input  logic [11:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ready,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        timeout_err
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;
  localparam logic [1:0] StErr    = 2'd3;

  // Wait count at which an unacknowledged access is abandoned.
  localparam logic [7:0] LastWait = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (memrq) begin
          state_d = StAccess;
          addr_d  = addr;
          wdata_d = wdata;
          we_d    = ~rnw;
          cnt_d   = 8'd0;
        end
      end
      StAccess: begin
        // An ack on the final wait cycle still completes the transfer normally.
        if (mem_ack) begin
          state_d = StDone;
          if (!we_q) rdata_d = mem_rdata;
        end else if (cnt_q == LastWait) begin
          state_d = StErr;
          rdata_d = 16'hFFFF;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      addr_q  <= 12'd0;
      wdata_q <= 16'd0;
      we_q    <= 1'b0;
      rdata_q <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // While reset is held the core sees the idle-state ready behaviour.
  always_comb begin
    if (rst) begin
      ready = ~memrq;
    end else begin
      ready = (state_q == StDone) || (state_q == StErr) || ((state_q == StIdle) && !memrq);
    end
  end

  assign mem_cs      = (state_q == StAccess);
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign rdata       = rdata_q;
  assign timeout_err = err_q;

endmodule

// File: doc/mu0_mem_ctrl.md
MU0_MEM_CTRL -- requirements
Module: mu0_mem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, maximum ACCESS-state cycles without mem_ack before abort; legal range 1..255.
REQ-002 SHALL have clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have memrq  input  1  memory request from MU0 control logic.
REQ-005 SHALL have rnw  input  1  1 = read, 0 = write; qualified by memrq.
REQ-006 SHALL have addr  input  12  word address from the PC/IR address mux.
REQ-007 SHALL have wdata  input  16  accumulator data for writes.
REQ-008 SHALL have rdata  output  16  read data to IR/ALU B input.
REQ-009 SHALL have ready  output  1  transfer complete or no transfer pending; core stalls while low.
REQ-010 SHALL have mem_cs  output  1  external memory chip select.
REQ-011 SHALL have mem_we  output  1  external write enable, valid while mem_cs=1.
REQ-012 SHALL have mem_addr  output  12  registered address to memory.
REQ-013 SHALL have mem_wdata  output  16  registered write data to memory.
REQ-014 SHALL have mem_rdata  input  16  memory read data, valid with mem_ack.
REQ-015 SHALL have mem_ack  input  1  memory completion strobe, one or more cycles.
REQ-016 SHALL have timeout_err  output  1  sticky abort flag.

Function
REQ-017 SHALL implement FSM with states IDLE, ACCESS, DONE, ERR.
REQ-018 IDLE and memrq=1 at a clock edge SHALL latch addr->mem_addr, wdata->mem_wdata, ~rnw->mem_we, set mem_cs=1, clear wait counter, go to ACCESS.
REQ-019 IDLE and memrq=0 SHALL hold mem_cs=0 and stay in IDLE.
REQ-020 In ACCESS, mem_cs SHALL stay 1 and mem_addr/mem_wdata/mem_we SHALL remain stable, independent of core inputs.
REQ-021 In ACCESS with mem_ack=1: for a read, SHALL load mem_rdata into rdata; for a write, SHALL leave rdata unchanged; SHALL clear mem_cs and go to DONE at that edge.
REQ-022 In ACCESS with mem_ack=0: SHALL increment 8-bit wait counter; when counter reaches TIMEOUT-1 at an edge, SHALL clear mem_cs, set rdata=16'hFFFF, set timeout_err=1, and go to ERR.
REQ-023 mem_ack=1 in the same edge as the timeout condition SHALL take priority; the access completes normally.
REQ-024 DONE and ERR SHALL each last exactly one cycle, then go to IDLE; memrq is not sampled in these states.
REQ-025 ready SHALL be combinational: 1 in DONE, 1 in ERR, 1 in IDLE when memrq=0, otherwise 0.
REQ-026 Latency: a zero-wait access (mem_ack in first ACCESS cycle) SHALL assert ready 2 cycles after the request edge; each extra ACCESS cycle adds 1.
REQ-027 Back-to-back requests SHALL incur one IDLE cycle between DONE and the next ACCESS.
REQ-028 mem_ack in IDLE, DONE or ERR SHALL be ignored.
REQ-029 rdata SHALL hold its last value until the next completed read or timeout.
REQ-030 timeout_err SHALL stay 1 until reset; later transfers SHALL proceed normally.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE, mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, wait counter=0, timeout_err=0, from any state including mid-ACCESS.
REQ-032 With rst=1, ready SHALL be driven from IDLE state (1 when memrq=0).

Verification
REQ-033 Read, zero wait: memrq=1,rnw=1,addr=0x005; mem_ack=1,mem_rdata=0x1234 in first ACCESS cycle -> mem_cs high 1 cycle, mem_we=0, ready=1 on cycle 2, rdata=0x1234.
REQ-034 Write, 3 waits: memrq=1,rnw=0,addr=0xABC,wdata=0x00FF; ack on 4th ACCESS cycle -> mem_we=1, mem_addr=0xABC, mem_wdata=0x00FF stable for 4 cycles, ready on cycle 5, rdata unchanged.
REQ-035 Timeout: TIMEOUT=4, read, no ack -> mem_cs drops after 4 ACCESS cycles, ready=1, rdata=0xFFFF, timeout_err=1 and stays 1 through a following good read.
REQ-036 Ack/timeout coincident: TIMEOUT=4, ack on 4th ACCESS cycle -> normal DONE, timeout_err=0.
REQ-037 Reset mid-access: rst at 2nd ACCESS cycle, then late mem_ack -> IDLE, mem_cs=0 next edge, ack ignored, rdata=0.
REQ-038 Back-to-back: memrq held high, two zero-wait reads -> mem_cs pulses separated by DONE and IDLE cycles, ready high once per read.
